rst_wr_rd_window_monitor: RTL and testbench

- Synthesizable protocol monitor placed directly downstream of the reset/write/read stimulus stage; it consumes that stage's mon_rst, mon_wr and mon_rd.
- Once armed, it checks two things:
  - mon_rst is high for exactly RST_CYCLES clock edges, then low for the following WIN_CYCLES edges.
  - Within that window, mon_wr and mon_rd are each sampled high at least once.
- Results go to a pass/fail flag and counters for on-chip or emulation self-check.

---
 rtl/rwm_pkg.sv | 15 +
 rtl/rwm_sat_cnt.sv | 34 +++
 rtl/rst_wr_rd_window_monitor.sv | 151 +++++++++++++++
 tb/tb_rst_wr_rd_window_monitor.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/rwm_pkg.sv
// Shared types and default sizing for the reset/write/read window monitor.
package rwm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RST_CHK = 2'd1,
        WINDOW  = 2'd2,
        DONE    = 2'd3
    } rwm_state_t;

    localparam int RWM_RST_CYCLES_DEF = 2;
    localparam int RWM_WIN_CYCLES_DEF = 10;
    localparam int RWM_CNT_W_DEF      = 8;

endpackage

// File: rtl/rwm_sat_cnt.sv
// Saturating event counter with synchronous clear; clr wins over inc.
module rwm_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/rst_wr_rd_window_monitor.sv
// Checks a reset pulse of RST_CYCLES edges followed by a WIN_CYCLES window with write and read activity.
// Optional first-rd-before-wr ordering check enabled by defining RWM_ORDER_CHK_EN.
module rst_wr_rd_window_monitor
    import rwm_pkg::*;
#(
    parameter int RST_CYCLES = RWM_RST_CYCLES_DEF,
    parameter int WIN_CYCLES = RWM_WIN_CYCLES_DEF,
    parameter int CNT_W      = RWM_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mon_rst,
    input  logic             mon_wr,
    input  logic             mon_rd,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef RWM_ORDER_CHK_EN
    output logic             order_err,
`endif
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wr_hits,
    output logic [CNT_W-1:0] rd_hits
);

    localparam int MAX_CYC = (RST_CYCLES > WIN_CYCLES) ? RST_CYCLES : WIN_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);
    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] WIN_LAST = CYC_W'(WIN_CYCLES - 1);

    if (RST_CYCLES < 1 || WIN_CYCLES < 1) begin : g_bad_params
        $error("RST_CYCLES and WIN_CYCLES must both be at least 1");
    end

    rwm_state_t       state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             start_acc;
    logic             err_inc, wr_inc, rd_inc;
    logic             order_ok;

    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        err_inc   = 1'b0;
        wr_inc    = 1'b0;
        rd_inc    = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = RST_CHK;
                    cyc_d     = '0;
                end
            end
            RST_CHK: begin
                err_inc = !mon_rst;
                if (cyc_q == RST_LAST) begin
                    state_d = WINDOW;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            WINDOW: begin
                err_inc = mon_rst;
                wr_inc  = !mon_rst && mon_wr;
                rd_inc  = !mon_rst && mon_rd;
                if (cyc_q == WIN_LAST) begin
                    state_d = DONE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = '0;
            end
        endcase

        // Verdict registers one edge after DONE is entered, so counters are final.
        busy_d = (state_d == RST_CHK) || (state_d == WINDOW);
        done_d = (state_q == DONE) && !start;
        pass_d = done_d && (err_cnt == '0) && (wr_hits != '0) && (rd_hits != '0) && order_ok;
    end

`ifdef RWM_ORDER_CHK_EN
    logic order_err_q, order_err_d;

    // A rd hit while no wr hit has been seen yet (same edge included) is an ordering error.
    always_comb begin
        order_err_d = order_err_q;
        if (start_acc) begin
            order_err_d = 1'b0;
        end else if (rd_inc && (wr_hits == '0)) begin
            order_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            order_err_q <= 1'b0;
        end else begin
            order_err_q <= order_err_d;
        end
    end

    assign order_ok  = !order_err_q;
    assign order_err = order_err_q;
`else
    assign order_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    rwm_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk (clk), .rst (rst), .clr (start_acc), .inc (err_inc), .q (err_cnt)
    );

    rwm_sat_cnt #(.W(CNT_W)) u_wr_hits (
        .clk (clk), .rst (rst), .clr (start_acc), .inc (wr_inc), .q (wr_hits)
    );

    rwm_sat_cnt #(.W(CNT_W)) u_rd_hits (
        .clk (clk), .rst (rst), .clr (start_acc), .inc (rd_inc), .q (rd_hits)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_rst_wr_rd_window_monitor.sv
// Scoreboard bench for rst_wr_rd_window_monitor; honours RWM_ORDER_CHK_EN when defined.
module tb_rst_wr_rd_window_monitor;

    localparam int CNT_W = 3;
`ifdef RWM_ORDER_CHK_EN
    localparam bit ORD_EN = 1'b1;
`else
    localparam bit ORD_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             mon_rst = 1'b0;
    logic             mon_wr = 1'b0;
    logic             mon_rd = 1'b0;
    logic             busy, done, pass;
    logic [CNT_W-1:0] err_cnt, wr_hits, rd_hits;
`ifdef RWM_ORDER_CHK_EN
    logic             order_err;
`endif

    rst_wr_rd_window_monitor #(.RST_CYCLES(2), .WIN_CYCLES(10), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mon_rst   (mon_rst),
        .mon_wr    (mon_wr),
        .mon_rd    (mon_rd),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
`ifdef RWM_ORDER_CHK_EN
        .order_err (order_err),
`endif
        .err_cnt   (err_cnt),
        .wr_hits   (wr_hits),
        .rd_hits   (rd_hits)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        string name;
        int    start_edge;
        int    err;
        int    wr;
        int    rd;
        int    pass;
        int    ord;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: on every rising done, pop the next expected verdict and compare.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (rst && done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_latency"}, edge_cnt - e.start_edge, 13);
                check({e.name, "_pass"}, int'(pass), e.pass);
                check({e.name, "_err_cnt"}, int'(err_cnt), e.err);
                check({e.name, "_wr_hits"}, int'(wr_hits), e.wr);
                check({e.name, "_rd_hits"}, int'(rd_hits), e.rd);
`ifdef RWM_ORDER_CHK_EN
                check({e.name, "_order_err"}, int'(order_err), e.ord);
`endif
            end
        end
        done_prev <= rst ? done : 1'b0;
    end

    task automatic check_zero(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_pass"}, int'(pass), 0);
        check({name, "_err_cnt"}, int'(err_cnt), 0);
        check({name, "_wr_hits"}, int'(wr_hits), 0);
        check({name, "_rd_hits"}, int'(rd_hits), 0);
`ifdef RWM_ORDER_CHK_EN
        check({name, "_order_err"}, int'(order_err), 0);
`endif
    endtask

    // Bit k of each pattern is driven for the k-th edge after the accepting edge.
    task automatic run(input string name, input logic [12:0] rp, input logic [12:0] wp,
                       input logic [12:0] dp, input logic [12:0] sp, input int abort_k,
                       input int e_err, input int e_wr, input int e_rd,
                       input int e_pass, input int e_ord);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        mon_rst = 1'b0;
        mon_wr  = 1'b0;
        mon_rd  = 1'b0;
        e.name = name; e.start_edge = edge_cnt + 1;
        e.err = e_err; e.wr = e_wr; e.rd = e_rd; e.pass = e_pass; e.ord = e_ord;
        if (abort_k == 0) exp_q.push_back(e);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start   = sp[k];
            mon_rst = rp[k];
            mon_wr  = wp[k];
            mon_rd  = dp[k];
            if (k == 6) begin
                check({name, "_busy_mid"}, int'(busy), 1);
                check({name, "_done_mid"}, int'(done), 0);
            end
            if (k == abort_k) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1; start = 1'b0; mon_rst = 1'b0; mon_wr = 1'b0; mon_rd = 1'b0;
                check_zero({name, "_after_rst"});
                return;
            end
        end
        @(negedge clk);
        start = 1'b0; mon_rst = 1'b0; mon_wr = 1'b0; mon_rd = 1'b0;
        repeat (3) @(negedge clk);
        check({name, "_pending"}, exp_q.size(), 0);
        while (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        check_zero("idle");

        //   name          mon_rst   mon_wr    mon_rd    start    abort err wr rd pass ord
        run("s1_basic",    13'h0006, 13'h0040, 13'h0400, 13'h0000, 0, 0, 1, 1, 1, 0);
        run("s2_rst_long", 13'h000E, 13'h0040, 13'h0400, 13'h0000, 0, 1, 1, 1, 0, 0);
        run("s3_no_rd",    13'h0006, 13'h0120, 13'h0000, 13'h0000, 0, 0, 2, 0, 0, 0);
        run("s4_rst_hit",  13'h0086, 13'h0080, 13'h0080, 13'h0000, 0, 1, 0, 0, 0, 0);
        run("rst_short",   13'h0004, 13'h0040, 13'h0400, 13'h0000, 0, 1, 1, 1, 0, 0);
        run("s5_abort",    13'h0006, 13'h0040, 13'h0400, 13'h0000, 8, 0, 0, 0, 0, 0);
        run("s5_fresh",    13'h0006, 13'h0040, 13'h0400, 13'h0000, 0, 0, 1, 1, 1, 0);
        run("s5_busy_st",  13'h0006, 13'h0040, 13'h0400, 13'h0020, 0, 0, 1, 1, 1, 0);
        run("same_edge",   13'h0006, 13'h0080, 13'h0080, 13'h0000, 0, 0, 1, 1,
            ORD_EN ? 0 : 1, ORD_EN ? 1 : 0);
        run("s6_rd_first", 13'h0006, 13'h0200, 13'h0020, 13'h0000, 0, 0, 1, 1,
            ORD_EN ? 0 : 1, ORD_EN ? 1 : 0);
        run("sat_err",     13'h1FF8, 13'h1FF8, 13'h0000, 13'h0000, 0, 7, 0, 0, 0, 0);
        run("sat_hits",    13'h0006, 13'h1FF8, 13'h1FF8, 13'h0000, 0, 0, 7, 7,
            ORD_EN ? 0 : 1, ORD_EN ? 1 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
